// File: rtl/io_rx_fifo_regs.sv
`default_nettype none
// ============================================================================
//  Module      : io_rx_fifo_regs
//  Description : Receive FIFO between a UART receiver and a two-register
//                I/O window. Received bytes are queued in a 2**A-entry
//                circular buffer. Register 0 shows the head byte and
//                register 1 shows the status. A sticky overflow flag records
//                any byte that was dropped because the FIFO was full.
//  Ports       :
//     clk          in   system clock, rising edge
//     reset        in   asynchronous active-high reset
//     rx_done_tick in   1-cycle strobe, rx_data valid
//     rx_data      in   [W-1:0] received byte
//     rd_ack       in   1-cycle strobe, pop head entry
//     clr_ovr      in   1-cycle strobe, clear overflow flag
//     regs_out     out  [2W-1:0] {status, head data}
//     rx_avail     out  FIFO non-empty
//  Status map  : bit0 empty, bit1 full, bit2 ovr, bits[3+A:3] count
//  Revision    : 1.0  initial release
// ============================================================================
module io_rx_fifo_regs #(
   parameter int W = 8,
   parameter int A = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           rx_done_tick,
   input  logic [W-1:0]   rx_data,
   input  logic           rd_ack,
   input  logic           clr_ovr,
   output logic [2*W-1:0] regs_out,
   output logic           rx_avail
);

   localparam int         DEPTH    = 2**A;
   localparam logic [A:0] FULL_CNT = (A+1)'(DEPTH);

   // Storage has no reset: after reset the pointers and count alone make
   // every old entry unreachable.
   logic [W-1:0] mem_q [DEPTH];

   logic [A-1:0] wr_ptr_q, wr_ptr_d;
   logic [A-1:0] rd_ptr_q, rd_ptr_d;
   logic [A:0]   count_q,  count_d;
   logic         ovr_q,    ovr_d;

   logic         empty;
   logic         full;
   logic         pop_ok;
   logic         push_ok;
   logic         drop;
   logic [W-1:0] status;
   logic [W-1:0] head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // byte when it is popped at the same time. A pop on an empty FIFO is
   // ignored, which also leaves a same-cycle push as a plain push.
   assign pop_ok  = rd_ack && !empty;
   assign push_ok = rx_done_tick && (!full || pop_ok);
   assign drop    = rx_done_tick && full && !pop_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovr_d    = ovr_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A new overflow takes priority over a same-cycle clear so that no
      // dropped byte can go unreported.
      if (drop) begin
         ovr_d = 1'b1;
      end else if (clr_ovr) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovr_q    <= ovr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   // Outputs decode registered state only; no input reaches them
   // combinationally.
   always_comb begin
      status          = '0;
      status[0]       = empty;
      status[1]       = full;
      status[2]       = ovr_q;
      status[3+A:3]   = count_q;
   end

   assign head     = empty ? '0 : mem_q[rd_ptr_q];
   assign regs_out = {status, head};
   assign rx_avail = !empty;

endmodule
`default_nettype wire

// File: doc/io_rx_fifo_regs.md
IO_RX_FIFO_REGS -- requirements
Module: io_rx_fifo_regs

Interface
REQ-001 Parameter W, default 8: data width in bits of each received byte and of each I/O register.
REQ-002 Parameter A, default 2: address width; FIFO depth is 2**A entries (default 4).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_done_tick  input  1  one-cycle strobe from the UART receiver: rx_data is valid this cycle.
REQ-006 rx_data  input  W  received byte.
REQ-007 rd_ack  input  1  one-cycle strobe: consumer has read register 0; pop the head entry.
REQ-008 clr_ovr  input  1  one-cycle strobe: clear the sticky overflow flag.
REQ-009 regs_out  output  2*W  I/O register bus for the downstream register-select mux: [W-1:0] = register 0 (data), [2W-1:W] = register 1 (status).
REQ-010 rx_avail  output  1  high whenever the FIFO is non-empty (interrupt/poll line).

Function
REQ-011 Storage SHALL be a 2**A x W circular buffer with A-bit write pointer, A-bit read pointer, and an (A+1)-bit occupancy count (0..2**A).
REQ-012 Push: on a clk edge with rx_done_tick=1 and (count<2**A or pop this cycle), rx_data SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo 2**A.
REQ-013 Pop: on a clk edge with rd_ack=1 and count>0, rd_ptr SHALL increment modulo 2**A; rd_ack with count=0 SHALL be ignored (no pointer or count change, no error flag).
REQ-014 Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-015 Simultaneous push and pop when full SHALL be accepted: the head is popped, the new byte is stored, count stays 2**A, and overflow is not set.
REQ-016 Simultaneous push and pop when empty: the pop is ignored, the push is accepted, and count becomes 1.
REQ-017 Overflow: rx_done_tick=1 while count=2**A and no valid pop SHALL drop the byte, leave pointers and count unchanged, and set ovr=1.
REQ-018 ovr SHALL be sticky; clr_ovr=1 clears it on the next edge; if a set condition and clr_ovr occur in the same cycle, the set wins (ovr=1).
REQ-019 Register 0 SHALL equal mem[rd_ptr] when count>0, else all zeros.
REQ-020 Register 1 bit map: bit0 empty (count==0), bit1 full (count==2**A), bit2 ovr, bits[3+A:3] count, remaining upper bits zero.
REQ-021 Latency: a byte pushed at edge k SHALL be visible on register 0 (if it is the head) and reflected in status immediately after edge k; no further pipeline delay.
REQ-022 rx_avail SHALL equal NOT empty.
REQ-023 regs_out and rx_avail SHALL be driven purely from registered state (no combinational path from any input).

Reset
REQ-024 reset=1 SHALL asynchronously force wr_ptr=0, rd_ptr=0, count=0, and ovr=0; the memory contents are not cleared.
REQ-025 During and after reset: regs_out = {8'h01, 8'h00} for default W=8, A=2, and rx_avail=0.
REQ-026 Reset asserted mid-operation (FIFO partially full, overflow set) SHALL discard all queued bytes; the first push after reset release is stored at entry 0.

Verification
REQ-027 Reset, then push 8'h41 -> next cycle register 0 = 8'h41, status = 8'h08 (count=1), rx_avail = 1; then rd_ack -> status = 8'h01, register 0 = 8'h00.
REQ-028 Push 8'h10, 8'h11, 8'h12, 8'h13 -> status = 8'h22 (full, count 4); pop four times -> head values 10, 11, 12, 13 in that order, then status = 8'h01.
REQ-029 Full FIFO, push 8'hAA with no rd_ack -> byte dropped, status = 8'h26; clr_ovr -> status = 8'h22; set condition and clr_ovr in the same cycle -> bit2 stays 1.
REQ-030 Full FIFO, push 8'h55 and rd_ack in the same cycle -> count stays 4, ovr = 0, and 8'h55 emerges as the fourth head after three more pops.
REQ-031 Wrap-around: 10 push/pop pairs with interleaved single pushes -> data order is preserved across pointer wrap and the count never exceeds 4.
REQ-032 Empty FIFO, rd_ack alone -> no change; empty FIFO, push 8'h7E and rd_ack in the same cycle -> count = 1, head = 8'h7E; assert reset with 3 entries queued -> status = 8'h01 immediately, without waiting for a clock edge.
